// File: rtl/router_switch_alloc.sv
// Wormhole switch allocator: XY route per input head flit, round-robin lock per output until tail.
// Define ROUTER_ALLOC_STATS_EN to add saturating per-output transfer counters on stat_flits.
module router_switch_alloc #(
    parameter int NUM_IN  = 5,
    parameter int COORD_W = 30,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0,
    parameter int IDX_W   = $clog2(NUM_IN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IN-1:0]          req_valid,
    input  logic [NUM_IN-1:0]          req_head,
    input  logic [NUM_IN-1:0]          req_tail,
    input  logic [NUM_IN*COORD_W-1:0]  req_dest_x,
    input  logic [NUM_IN*COORD_W-1:0]  req_dest_y,
    output logic [NUM_IN-1:0]          req_ready,
    input  logic [4:0]                 out_ready,
    output logic [4:0]                 out_valid,
    output logic [5*IDX_W-1:0]         out_src
`ifdef ROUTER_ALLOC_STATS_EN
    ,
    output logic [5*16-1:0]            stat_flits
`endif
);

    localparam int NUM_OUT = 5;
    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_EAST  = 3'd1;
    localparam logic [2:0] P_WEST  = 3'd2;
    localparam logic [2:0] P_NORTH = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;
    localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t             r_state     [NUM_OUT];
    state_t             w_state_nxt [NUM_OUT];
    logic [IDX_W-1:0]   r_owner     [NUM_OUT];
    logic [IDX_W-1:0]   w_owner_nxt [NUM_OUT];
    logic [IDX_W-1:0]   r_ptr       [NUM_OUT];
    logic [IDX_W-1:0]   w_ptr_nxt   [NUM_OUT];
    logic [2:0]         w_route     [NUM_IN];
    logic [NUM_IN-1:0]  w_req       [NUM_OUT];
    logic [NUM_IN-1:0]  w_owns;
    logic [NUM_OUT-1:0] w_xfer;

    // XY route of the flit currently presented at each input
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (req_dest_x[i*COORD_W +: COORD_W] > LX) begin
                w_route[i] = P_EAST;
            end else if (req_dest_x[i*COORD_W +: COORD_W] < LX) begin
                w_route[i] = P_WEST;
            end else if (req_dest_y[i*COORD_W +: COORD_W] > LY) begin
                w_route[i] = P_NORTH;
            end else if (req_dest_y[i*COORD_W +: COORD_W] < LY) begin
                w_route[i] = P_SOUTH;
            end else begin
                w_route[i] = P_LOCAL;
            end
        end
    end

    // request matrix: only valid head flits of inputs that hold no output
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                w_req[o][i] = req_valid[i] & req_head[i] & ~w_owns[i] & (w_route[i] == 3'(o));
            end
        end
    end

    // per-output FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                r_state[o] <= ST_IDLE;
                r_owner[o] <= {IDX_W{1'b0}};
                r_ptr[o]   <= {IDX_W{1'b0}};
            end
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                r_state[o] <= w_state_nxt[o];
                r_owner[o] <= w_owner_nxt[o];
                r_ptr[o]   <= w_ptr_nxt[o];
            end
        end
    end

    // per-output next state: round-robin grant in IDLE, release on tail transfer
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            w_state_nxt[o] = r_state[o];
            w_owner_nxt[o] = r_owner[o];
            w_ptr_nxt[o]   = r_ptr[o];
            case (r_state[o])
                ST_IDLE: begin
                    // scanned backwards so the requester nearest rr_ptr is written last and wins
                    for (int k = NUM_IN - 1; k >= 0; k--) begin
                        if (w_req[o][(int'(r_ptr[o]) + k) % NUM_IN]) begin
                            w_state_nxt[o] = ST_LOCKED;
                            w_owner_nxt[o] = IDX_W'((int'(r_ptr[o]) + k) % NUM_IN);
                            w_ptr_nxt[o]   = IDX_W'((int'(r_ptr[o]) + k + 1) % NUM_IN);
                        end else begin
                            w_state_nxt[o] = w_state_nxt[o];
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer[o] && req_tail[r_owner[o]]) begin
                        w_state_nxt[o] = ST_IDLE;
                    end else begin
                        w_state_nxt[o] = ST_LOCKED;
                    end
                end
                default: begin
                    w_state_nxt[o] = ST_IDLE;
                end
            endcase
        end
    end

    // handshakes and crossbar select from the locked owners
    always_comb begin
        out_valid = 5'b00000;
        req_ready = {NUM_IN{1'b0}};
        w_owns    = {NUM_IN{1'b0}};
        out_src   = {(5*IDX_W){1'b0}};
        for (int o = 0; o < NUM_OUT; o++) begin
            out_src[o*IDX_W +: IDX_W] = r_owner[o];
            if (r_state[o] == ST_LOCKED) begin
                out_valid[o]          = req_valid[r_owner[o]];
                w_owns[r_owner[o]]    = 1'b1;
                req_ready[r_owner[o]] = req_valid[r_owner[o]] & out_ready[o];
            end else begin
                out_valid[o] = 1'b0;
            end
        end
        w_xfer = out_valid & out_ready;
    end

`ifdef ROUTER_ALLOC_STATS_EN
    logic [15:0] r_stat [NUM_OUT];

    // saturating transfer counter per output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                r_stat[o] <= 16'd0;
            end
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                if (w_xfer[o] && (r_stat[o] != 16'hFFFF)) begin
                    r_stat[o] <= r_stat[o] + 16'd1;
                end else begin
                    r_stat[o] <= r_stat[o];
                end
            end
        end
    end

    // flatten counters onto the stats port
    always_comb begin
        stat_flits = {(5*16){1'b0}};
        for (int o = 0; o < NUM_OUT; o++) begin
            stat_flits[o*16 +: 16] = r_stat[o];
        end
    end
`endif

endmodule

// File: tb/tb_router_switch_alloc.sv
// Self-checking bench for router_switch_alloc with LOCAL=(3,3): directed scenarios plus
// randomized packet traffic compared against a per-output ownership model.
module tb_router_switch_alloc;

    localparam int N  = 5;
    localparam int CW = 30;
    localparam int IW = 3;
    localparam int LX = 3;
    localparam int LY = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_head, req_tail, req_ready;
    logic [N*CW-1:0]  req_dest_x, req_dest_y;
    logic [4:0]       out_ready, out_valid;
    logic [5*IW-1:0]  out_src;
`ifdef ROUTER_ALLOC_STATS_EN
    logic [79:0]      stat_flits;
`endif

    int n_cmp;
    int n_bad;

    // model: owner per output (-1 = idle), round-robin pointer, last owner shown on out_src
    int m_owner [5];
    int m_ptr   [5];
    int m_last  [5];
    logic [4:0]      e_valid;
    logic [N-1:0]    e_ready;
    logic [5*IW-1:0] e_src;

    router_switch_alloc #(.NUM_IN(N), .COORD_W(CW), .LOCAL_X(LX), .LOCAL_Y(LY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_ready(req_ready),
        .out_ready(out_ready), .out_valid(out_valid), .out_src(out_src)
`ifdef ROUTER_ALLOC_STATS_EN
        , .stat_flits(stat_flits)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic int route_of(int i);
        int x, y;
        x = int'(req_dest_x[i*CW +: CW]);
        y = int'(req_dest_y[i*CW +: CW]);
        if (x > LX) return 1;
        if (x < LX) return 2;
        if (y > LY) return 3;
        if (y < LY) return 4;
        return 0;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < 5; o++) begin
            m_owner[o] = -1;
            m_ptr[o]   = 0;
            m_last[o]  = 0;
        end
    endtask

    task automatic model_eval();
        e_valid = 5'b0;
        e_ready = '0;
        e_src   = '0;
        for (int o = 0; o < 5; o++) begin
            e_src[o*IW +: IW] = IW'(m_last[o]);
            if (!rst && m_owner[o] >= 0) begin
                e_valid[o] = req_valid[m_owner[o]];
                if (e_valid[o] && out_ready[o]) e_ready[m_owner[o]] = 1'b1;
            end
        end
    endtask

    task automatic model_commit();
        bit owned [N];
        int ow, ii;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) owned[i] = 1'b0;
        for (int o = 0; o < 5; o++) if (m_owner[o] >= 0) owned[m_owner[o]] = 1'b1;
        for (int o = 0; o < 5; o++) begin
            ow = m_owner[o];
            if (ow >= 0) begin
                if (req_valid[ow] && out_ready[o] && req_tail[ow]) m_owner[o] = -1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    ii = (m_ptr[o] + k) % N;
                    if (!owned[ii] && req_valid[ii] && req_head[ii] && route_of(ii) == o) begin
                        m_owner[o] = ii;
                        m_last[o]  = ii;
                        m_ptr[o]   = (ii + 1) % N;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_head   = '0;
        req_tail   = '0;
        req_dest_x = '0;
        req_dest_y = '0;
        out_ready  = 5'b11111;
    endtask

    task automatic set_flit(int i, bit v, bit h, bit t, int x, int y);
        req_valid[i] = v;
        req_head[i]  = h;
        req_tail[i]  = t;
        req_dest_x[i*CW +: CW] = CW'(x);
        req_dest_y[i*CW +: CW] = CW'(y);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        tick();
        #1;
        n_cmp++; if (out_valid !== 5'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 00000", out_valid); end
        n_cmp++; if (req_ready !== 5'b0) begin n_bad++; $display("FAIL reset_req_ready got %b want 00000", req_ready); end
        n_cmp++; if (out_src !== 15'b0) begin n_bad++; $display("FAIL reset_out_src got %h want 0", out_src); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_flit();
        set_flit(0, 1'b1, 1'b1, 1'b1, 5, 1);
        #1;
        n_cmp++; if (out_valid !== 5'b0 || req_ready !== 5'b0) begin n_bad++;
            $display("FAIL single_t0 valid=%b ready=%b want 00000/00000", out_valid, req_ready); end
        tick(); #1;
        n_cmp++; if (out_valid !== 5'b00010 || req_ready !== 5'b00001 || out_src[IW +: IW] !== 3'd0) begin n_bad++;
            $display("FAIL single_t1 valid=%b ready=%b src1=%0d want 00010/00001/0", out_valid, req_ready, out_src[IW +: IW]); end
        tick(); #1;
        n_cmp++; if (out_valid !== 5'b0) begin n_bad++;
            $display("FAIL single_idle_t2 valid=%b want 00000", out_valid); end
        tick(); #1;
        n_cmp++; if (out_valid !== 5'b00010 || req_ready !== 5'b00001) begin n_bad++;
            $display("FAIL single_regrant valid=%b ready=%b want 00010/00001", out_valid, req_ready); end
        tick();
        clear_inputs();
    endtask

    task automatic test_rr_local();
        int fl [N];
        int tc [N];
        logic [N-1:0] rdy;
        bit act;
        for (int i = 0; i < N; i++) begin fl[i] = 0; tc[i] = -1; end
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < N; i++) begin
                act = (i == 1 || i == 2 || i == 4) && fl[i] < 3;
                set_flit(i, act, fl[i] == 0, fl[i] == 2, 3, 3);
            end
            #1; model_eval();
            n_cmp++; if ({out_valid, req_ready, out_src} !== {e_valid, e_ready, e_src}) begin n_bad++;
                $display("FAIL rr_model c=%0d valid=%b/%b ready=%b/%b src=%h/%h", c, out_valid, e_valid, req_ready, e_ready, out_src, e_src); end
            rdy = req_ready;
            for (int i = 0; i < N; i++) if (rdy[i] && req_tail[i]) tc[i] = c;
            tick();
            for (int i = 0; i < N; i++) if (rdy[i]) fl[i]++;
            if (fl[1] == 3 && fl[2] == 3 && fl[4] == 3) break;
        end
        clear_inputs();
        n_cmp++; if (tc[1] != 3) begin n_bad++; $display("FAIL rr_tail_in1 cycle=%0d want 3", tc[1]); end
        n_cmp++; if (tc[2] != 7) begin n_bad++; $display("FAIL rr_tail_in2 cycle=%0d want 7", tc[2]); end
        n_cmp++; if (tc[4] != 11) begin n_bad++; $display("FAIL rr_tail_in4 cycle=%0d want 11", tc[4]); end
    endtask

    task automatic test_stall();
        int fl, tcyc;
        logic rdy;
        fl = 0; tcyc = -1;
        for (int c = 0; c < 20; c++) begin
            set_flit(0, fl < 4, fl == 0, fl == 3, 5, 1);
            out_ready = (c >= 3 && c <= 5) ? 5'b11101 : 5'b11111;
            #1; model_eval();
            n_cmp++; if ({out_valid, req_ready, out_src} !== {e_valid, e_ready, e_src}) begin n_bad++;
                $display("FAIL stall_model c=%0d valid=%b/%b ready=%b/%b src=%h/%h", c, out_valid, e_valid, req_ready, e_ready, out_src, e_src); end
            if (c >= 3 && c <= 5) begin
                n_cmp++; if (req_ready[0] !== 1'b0 || out_valid[1] !== 1'b1 || out_src[IW +: IW] !== 3'd0) begin n_bad++;
                    $display("FAIL stall_hold c=%0d ready0=%b valid1=%b src1=%0d want 0/1/0", c, req_ready[0], out_valid[1], out_src[IW +: IW]); end
            end
            rdy = req_ready[0];
            if (rdy && fl == 3) tcyc = c;
            tick();
            if (rdy) fl++;
            if (fl == 4) break;
        end
        clear_inputs();
        n_cmp++; if (tcyc != 7) begin n_bad++; $display("FAIL stall_tail cycle=%0d want 7", tcyc); end
    endtask

    task automatic test_body_idle();
        set_flit(3, 1'b1, 1'b0, 1'b0, 5, 5);
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++; if (req_ready[3] !== 1'b0 || out_valid !== 5'b0) begin n_bad++;
                $display("FAIL body_idle c=%0d ready3=%b valid=%b want 0/00000", c, req_ready[3], out_valid); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            set_flit(2, 1'b1, c <= 1, 1'b0, 3, 6);
            #1; model_eval();
            n_cmp++; if ({out_valid, req_ready, out_src} !== {e_valid, e_ready, e_src}) begin n_bad++;
                $display("FAIL mid_model c=%0d valid=%b/%b ready=%b/%b src=%h/%h", c, out_valid, e_valid, req_ready, e_ready, out_src, e_src); end
            tick();
        end
        set_flit(2, 1'b1, 1'b0, 1'b0, 3, 6);
        #1;
        n_cmp++; if (out_valid !== 5'b01000) begin n_bad++; $display("FAIL mid_locked valid=%b want 01000", out_valid); end
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (out_valid !== 5'b0 || req_ready !== 5'b0 || out_src !== 15'b0) begin n_bad++;
            $display("FAIL mid_reset_async valid=%b ready=%b src=%h want all 0", out_valid, req_ready, out_src); end
        tick(); #1;
        n_cmp++; if (out_valid !== 5'b0 || req_ready !== 5'b0 || out_src !== 15'b0) begin n_bad++;
            $display("FAIL mid_reset_held valid=%b ready=%b src=%h want all 0", out_valid, req_ready, out_src); end
        rst = 1'b0;
        clear_inputs();
        set_flit(1, 1'b1, 1'b1, 1'b1, 3, 6);
        #1;
        n_cmp++; if (out_valid !== 5'b0) begin n_bad++; $display("FAIL mid_fresh_t0 valid=%b want 00000", out_valid); end
        tick(); #1;
        n_cmp++; if (out_valid !== 5'b01000 || out_src[3*IW +: IW] !== 3'd1 || req_ready !== 5'b00010) begin n_bad++;
            $display("FAIL mid_fresh_t1 valid=%b src3=%0d ready=%b want 01000/1/00010", out_valid, out_src[3*IW +: IW], req_ready); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        int rem [N];
        bit hd  [N];
        int dx  [N];
        int dy  [N];
        logic [N-1:0] rdy;
        for (int i = 0; i < N; i++) begin rem[i] = 0; hd[i] = 1'b0; dx[i] = 0; dy[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(3, 0) != 0) begin
                    rem[i] = $urandom_range(4, 1);
                    hd[i]  = 1'b1;
                    dx[i]  = $urandom_range(6, 0);
                    dy[i]  = $urandom_range(6, 0);
                end
                set_flit(i, rem[i] > 0 && $urandom_range(4, 0) != 0, hd[i], rem[i] == 1, dx[i], dy[i]);
            end
            out_ready = 5'($urandom);
            #1; model_eval();
            n_cmp++; if ({out_valid, req_ready, out_src} !== {e_valid, e_ready, e_src}) begin n_bad++;
                $display("FAIL random c=%0d valid=%b/%b ready=%b/%b src=%h/%h", c, out_valid, e_valid, req_ready, e_ready, out_src, e_src); end
            rdy = req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    rem[i]--;
                    hd[i] = 1'b0;
                end
            end
        end
        clear_inputs();
        for (int c = 0; c < 3; c++) tick();
    endtask

`ifdef ROUTER_ALLOC_STATS_EN
    task automatic test_stats();
        int sent;
        sent = 0;
        clear_inputs();
        for (int c = 0; c < 70100 && sent < 70000; c++) begin
            set_flit(0, 1'b1, sent == 0, sent == 69999, 3, 0);
            #1;
            if (req_ready[0]) sent++;
            tick();
        end
        clear_inputs();
        n_cmp++; if (sent != 70000) begin n_bad++; $display("FAIL stats_sent got %0d want 70000", sent); end
        n_cmp++; if (stat_flits[4*16 +: 16] !== 16'hFFFF) begin n_bad++;
            $display("FAIL stats_south got %h want ffff", stat_flits[4*16 +: 16]); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_flit();
        test_rr_local();
        test_stall();
        test_body_idle();
        test_reset_mid();
        test_random();
`ifdef ROUTER_ALLOC_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
